// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter that shares a byte-wide, 1-cycle-latency read memory between the
// fetch and load ports, assembling four byte reads into one little-endian word per request.
module riscv_mem_arbiter #(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int NUM_MEM     = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req_valid,
    output logic                   if_req_ready,
    input  logic [ADDR_WIDTH-1:0]  if_req_addr,
    output logic                   if_resp_valid,
    output logic [WORD_LENGTH-1:0] if_resp_data,
    output logic                   if_resp_err,
    input  logic                   d_req_valid,
    output logic                   d_req_ready,
    input  logic [ADDR_WIDTH-1:0]  d_req_addr,
    output logic                   d_resp_valid,
    output logic [WORD_LENGTH-1:0] d_resp_data,
    output logic                   d_resp_err,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [7:0]             mem_rd_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Highest legal word base: base+3 must still be inside the memory.
    localparam logic [ADDR_WIDTH-1:0] MAX_BASE = ADDR_WIDTH'(NUM_MEM - 4);

    logic [1:0]            state;
    logic [2:0]            cnt;
    logic                  owner;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] base;
    logic [23:0]           byte_buf;

    logic                  grant_valid;
    logic                  grant;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic                  addr_err;

    // Arbitration: a lone requester wins; on contention the port not served last wins.
    always_comb begin
        grant_valid = 1'b0;
        grant       = OWN_IF;
        if (state == IDLE && !rst) begin
            if (if_req_valid && d_req_valid) begin
                grant_valid = 1'b1;
                grant       = ~last_grant;
            end else if (if_req_valid) begin
                grant_valid = 1'b1;
                grant       = OWN_IF;
            end else if (d_req_valid) begin
                grant_valid = 1'b1;
                grant       = OWN_D;
            end
        end
        if_req_ready = grant_valid && (grant == OWN_IF);
        d_req_ready  = grant_valid && (grant == OWN_D);
        acc_addr     = (grant == OWN_D) ? d_req_addr : if_req_addr;
        addr_err     = acc_addr > MAX_BASE;
    end

    always_comb begin
        mem_rd_en     = (state == READ) && (cnt < 3'd4);
        mem_addr      = mem_rd_en ? base + ADDR_WIDTH'(cnt) : '0;
        if_resp_valid = (state == RESP) && (owner == OWN_IF);
        d_resp_valid  = (state == RESP) && (owner == OWN_D);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            owner        <= OWN_IF;
            last_grant   <= OWN_D;
            base         <= '0;
            byte_buf     <= '0;
            if_resp_data <= '0;
            if_resp_err  <= 1'b0;
            d_resp_data  <= '0;
            d_resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant;
                        last_grant <= grant;
                        base       <= acc_addr;
                        cnt        <= '0;
                        byte_buf   <= '0;
                        if (addr_err) begin
                            state <= RESP;
                            if (grant == OWN_IF) begin
                                if_resp_data <= '0;
                                if_resp_err  <= 1'b1;
                            end else begin
                                d_resp_data <= '0;
                                d_resp_err  <= 1'b1;
                            end
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    // Each cycle returns the byte addressed one cycle earlier.
                    case (cnt)
                        3'd1:    byte_buf[7:0]   <= mem_rd_data;
                        3'd2:    byte_buf[15:8]  <= mem_rd_data;
                        3'd3:    byte_buf[23:16] <= mem_rd_data;
                        default: ;
                    endcase
                    if (cnt == 3'd4) begin
                        state <= RESP;
                        if (owner == OWN_IF) begin
                            if_resp_data <= WORD_LENGTH'({mem_rd_data, byte_buf});
                            if_resp_err  <= 1'b0;
                        end else begin
                            d_resp_data <= WORD_LENGTH'({mem_rd_data, byte_buf});
                            d_resp_err  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
